// File: rtl/paint_pkg.sv
// Shared types and default screen geometry for the brush painter.
// Holds the stroke FSM state encoding used by brush_painter.
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PAINT = 2'd2,
        DONE  = 2'd3
    } paint_state_t;

    typedef logic [2:0] color_t;
    typedef logic [9:0] coord_t;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage

// File: rtl/brush_mask.sv
// In-circle test for the round brush: dx^2 + dy^2 <= r^2 on absolute offsets.
// Purely combinational, no backpressure; used only when BRUSH_ROUND_EN is defined.
module brush_mask (
    input  logic [2:0] i_dx,
    input  logic [2:0] i_dy,
    input  logic [2:0] i_r,
    output logic       o_in_shape
);

    logic [6:0] w_dx2;
    logic [6:0] w_dy2;
    logic [6:0] w_r2;
    logic [6:0] w_sum;

    // Offsets never exceed 7, so 49 + 49 still fits in 7 bits.
    assign w_dx2      = 7'(i_dx) * 7'(i_dx);
    assign w_dy2      = 7'(i_dy) * 7'(i_dy);
    assign w_r2       = 7'(i_r) * 7'(i_r);
    assign w_sum      = w_dx2 + w_dy2;
    assign o_in_shape = (w_sum <= w_r2);

endmodule

// File: rtl/brush_painter.sv
// Expands one brush command into a clipped row-major stream of pixel writes, one per clock.
// Latency: accept -> SETUP (1) -> N PAINT cycles -> DONE (1); wr_allow low stalls one cycle each.
// Backpressure: cmd_ready only in IDLE; define BRUSH_ROUND_EN for a circular brush mask.
module brush_painter
    import paint_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    input  logic [2:0] cmd_radius,
    input  logic [2:0] cmd_color,
    input  logic       wr_allow,
    output logic       brush,
    output logic [9:0] wx,
    output logic [9:0] wy,
    output logic [2:0] newColor,
    output logic       busy,
    output logic       done
);

    localparam logic signed [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic signed [10:0] Y_MAX = 11'(V_RES - 1);

    paint_state_t r_state;
    paint_state_t w_next;

    coord_t     r_x, r_y;
    logic [2:0] r_r;
    color_t     r_col;
    coord_t     r_xlo, r_xhi, r_ylo, r_yhi;
    coord_t     r_cx, r_cy;
    logic       r_rdy_en;

    logic signed [10:0] w_xm, w_xp, w_ym, w_yp;
    logic signed [10:0] w_xlo, w_xhi, w_ylo, w_yhi;
    logic               w_empty;
    logic               w_last;
    logic               w_in_shape;

    // Bounds are evaluated in signed arithmetic so a negative low edge clamps rather than wraps.
    assign w_xm    = $signed({1'b0, r_x}) - $signed({8'b0, r_r});
    assign w_xp    = $signed({1'b0, r_x}) + $signed({8'b0, r_r});
    assign w_ym    = $signed({1'b0, r_y}) - $signed({8'b0, r_r});
    assign w_yp    = $signed({1'b0, r_y}) + $signed({8'b0, r_r});
    assign w_xlo   = w_xm[10] ? 11'sd0 : w_xm;
    assign w_ylo   = w_ym[10] ? 11'sd0 : w_ym;
    assign w_xhi   = (w_xp > X_MAX) ? X_MAX : w_xp;
    assign w_yhi   = (w_yp > Y_MAX) ? Y_MAX : w_yp;
    assign w_empty = (w_xlo > w_xhi) || (w_ylo > w_yhi);
    assign w_last  = (r_cx == r_xhi) && (r_cy == r_yhi);

`ifdef BRUSH_ROUND_EN
    logic [3:0] w_dx4, w_dy4;
    logic [2:0] w_dxa, w_dya;

    // Offsets are within +/-7 while painting, so 4-bit wraparound differences are exact.
    assign w_dx4 = r_cx[3:0] - r_x[3:0];
    assign w_dy4 = r_cy[3:0] - r_y[3:0];
    assign w_dxa = w_dx4[3] ? 3'(-w_dx4) : w_dx4[2:0];
    assign w_dya = w_dy4[3] ? 3'(-w_dy4) : w_dy4[2:0];

    brush_mask u_mask (
        .i_dx       (w_dxa),
        .i_dy       (w_dya),
        .i_r        (r_r),
        .o_in_shape (w_in_shape)
    );
`else
    assign w_in_shape = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        brush     = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = r_rdy_en;
                if (cmd_valid && r_rdy_en) w_next = SETUP;
            end
            SETUP: w_next = w_empty ? DONE : PAINT;
            PAINT: begin
                brush = wr_allow & w_in_shape;
                if (wr_allow && w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_r   <= '0;
            r_col <= '0;
            r_xlo <= '0;
            r_xhi <= '0;
            r_ylo <= '0;
            r_yhi <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_x   <= cmd_x;
                        r_y   <= cmd_y;
                        r_r   <= cmd_radius;
                        r_col <= cmd_color;
                    end
                end
                SETUP: begin
                    r_xlo <= w_xlo[9:0];
                    r_xhi <= w_xhi[9:0];
                    r_ylo <= w_ylo[9:0];
                    r_yhi <= w_yhi[9:0];
                    r_cx  <= w_xlo[9:0];
                    r_cy  <= w_ylo[9:0];
                end
                PAINT: begin
                    if (wr_allow) begin
                        if (r_cx == r_xhi) begin
                            r_cx <= r_xlo;
                            r_cy <= r_cy + 10'd1;
                        end else begin
                            r_cx <= r_cx + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wx       = r_cx;
    assign wy       = r_cy;
    assign newColor = r_col;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_brush_painter.sv
// Directed, table-driven bench for brush_painter: stroke vectors plus reset and busy sequences.
// Expected coordinates come from hand-computed clipped bounds in the vector table.
module tb_brush_painter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x = '0;
    logic [9:0] cmd_y = '0;
    logic [2:0] cmd_radius = '0;
    logic [2:0] cmd_color = '0;
    logic       wr_allow = 1'b1;
    logic       brush;
    logic [9:0] wx, wy;
    logic [2:0] newColor;
    logic       busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    brush_painter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_radius (cmd_radius),
        .cmd_color  (cmd_color),
        .wr_allow   (wr_allow),
        .brush      (brush),
        .wx         (wx),
        .wy         (wy),
        .newColor   (newColor),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int x, y, r, col;
        int xlo, xhi, ylo, yhi;
        int nwr;
        int done_cyc;
        int stall_at, stall_len;
        bit hold_valid;
    } vec_t;

    typedef struct {
        int x, y;
    } pt_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        pt_t q[$];
        int  k = 0;
        int  dcyc = -1;
        bit  ready_bad = 0;
        bit  fin = 0;
        bit  round_en = 0;
`ifdef BRUSH_ROUND_EN
        round_en = 1;
`endif
        for (int yy = v.ylo; yy <= v.yhi; yy++)
            for (int xx = v.xlo; xx <= v.xhi; xx++)
                if (!round_en || ((xx - v.x) * (xx - v.x) + (yy - v.y) * (yy - v.y) <= v.r * v.r))
                    q.push_back('{xx, yy});

        @(posedge clk); #1;
        cmd_x      = 10'(v.x);
        cmd_y      = 10'(v.y);
        cmd_radius = 3'(v.r);
        cmd_color  = 3'(v.col);
        cmd_valid  = 1'b1;
        wr_allow   = 1'b1;
        @(negedge clk);
        chk("ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        if (v.hold_valid) begin
            cmd_x     = 10'd200;
            cmd_color = 3'd3;
        end else begin
            cmd_valid = 1'b0;
        end

        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            wr_allow = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            if (v.hold_valid && cyc == v.done_cyc + 1) cmd_valid = 1'b0;
            @(negedge clk);
            if (!wr_allow && k < q.size()) begin
                chk("stall_hold_x", int'(wx), q[k].x);
                chk("stall_hold_y", int'(wy), q[k].y);
                chk("stall_no_write", int'(brush), 0);
            end
            if (brush) begin
                if (k < q.size()) begin
                    chk("write_x", int'(wx), q[k].x);
                    chk("write_y", int'(wy), q[k].y);
                    chk("write_color", int'(newColor), v.col);
                end
                k++;
            end
            if (done && dcyc < 0) dcyc = cyc;
            if (cyc <= v.done_cyc && cmd_ready) ready_bad = 1;
            if (dcyc >= 0 && cyc == dcyc + 1) begin
                chk("ready_after_done", int'(cmd_ready), 1);
                chk("idle_after_done", int'(busy), 0);
                fin = 1;
            end
        end
        chk("write_count", k, v.nwr);
        chk("done_cycle", dcyc, v.done_cyc);
        chk("ready_low_during_stroke", int'(ready_bad), 0);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int rnd_n  = 25;
        int clip_n = 4;
        int k;
        bit seen;
`ifdef BRUSH_ROUND_EN
        rnd_n  = 13;
        clip_n = 3;
`endif
        //         x    y    r col  xlo  xhi  ylo  yhi  nwr  done stall len hold
        vecs[0] = '{10,  20,  1, 5,  9,   11,  19,  21,  9,     11, 0,   0,  1'b0};
        vecs[1] = '{0,   0,   2, 3,  0,   2,   0,   2,   9,     11, 0,   0,  1'b0};
        vecs[2] = '{100, 100, 1, 6,  99,  101, 99,  101, 9,     14, 5,   3,  1'b0};
        vecs[3] = '{700, 10,  2, 4,  1,   0,   1,   0,   0,     2,  0,   0,  1'b0};
        vecs[4] = '{50,  50,  2, 2,  48,  52,  48,  52,  rnd_n, 27, 0,   0,  1'b0};
        vecs[5] = '{639, 479, 1, 1,  638, 639, 478, 479, clip_n, 6, 0,   0,  1'b0};

        #2;
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_brush", int'(brush), 0);
        chk("reset_wx", int'(wx), 0);
        chk("reset_wy", int'(wy), 0);
        chk("reset_color", int'(newColor), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(cmd_ready), 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // cmd_valid held through a whole stroke with changing payload: only one stroke, original data.
        begin
            vec_t hv;
            hv = vecs[0];
            hv.hold_valid = 1'b1;
            run_vec(hv);
        end

        // Reset asserted right after the 4th write of a stroke.
        @(posedge clk); #1;
        cmd_x = 10'd10; cmd_y = 10'd20; cmd_radius = 3'd1; cmd_color = 3'd5;
        cmd_valid = 1'b1; wr_allow = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            @(negedge clk);
            if (brush) k++;
        end
        chk("writes_before_reset", k, 4);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_brush", int'(brush), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_ready", int'(cmd_ready), 0);
        chk("rst_mid_wx", int'(wx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (brush || busy || done) seen = 1;
        end
        chk("no_activity_after_reset", int'(seen), 0);
        chk("ready_after_mid_reset", int'(cmd_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
